// File: rtl/mul_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mul_issue_ctrl
//   Two-stage valid/ready wrapper around an external combinational signed
//   32x32 multiplier core.
//   Stage 1 registers the RV32M operands and drives them to the core.
//   Stage 2 registers the corrected result, which is either the low or the
//   high half of the product, and the destination tag for writeback.
//   The core always multiplies signed x signed. MULHSU and MULHU results are
//   recovered by adding the operand-sign corrections to the high half.
//
// Ports
//   CLK          clock, rising edge
//   rst_n        asynchronous active-low reset
//   flush        synchronous kill of all in-flight ops
//   in_valid     request valid
//   in_ready     request accepted when in_valid && in_ready
//   funct3       000 MUL, 001 MULH, 010 MULHSU, 011 MULHU (bit 2 ignored)
//   rs1, rs2     operands
//   rd_in        destination tag
//   Multiplier   to core, registered stage-1 rs1
//   Multiplicand to core, registered stage-1 rs2
//   Product      signed 2*XLEN product from core (combinational)
//   out_valid    result valid
//   out_ready    writeback accepts
//   result       selected XLEN-bit result
//   rd_out       tag of result
// -----------------------------------------------------------------------------
module mul_issue_ctrl #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          funct3,
  input  logic [XLEN-1:0]     rs1,
  input  logic [XLEN-1:0]     rs2,
  input  logic [TAG_W-1:0]    rd_in,
  output logic [XLEN-1:0]     Multiplier,
  output logic [XLEN-1:0]     Multiplicand,
  input  logic [2*XLEN-1:0]   Product,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     result,
  output logic [TAG_W-1:0]    rd_out
);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  // Converts the signed x signed core product into the RV32M result.
  // For an operand x read as unsigned, x_u = x_s + x[msb] * 2^XLEN. Each
  // operand that is treated as unsigned therefore contributes the other
  // operand to the high half when its own sign bit is set. The MULHU cross
  // term 2^(2*XLEN) falls outside the high half and is dropped.
  function automatic logic [XLEN-1:0] correct_result(
    input logic [1:0]        op,
    input logic [2*XLEN-1:0] prod,
    input logic [XLEN-1:0]   a,
    input logic [XLEN-1:0]   b
  );
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] add_a;
    logic [XLEN-1:0] add_b;
    hi    = prod[2*XLEN-1:XLEN];
    add_a = b[XLEN-1] ? a : {XLEN{1'b0}};
    add_b = a[XLEN-1] ? b : {XLEN{1'b0}};
    case (op)
      OP_MUL:    correct_result = prod[XLEN-1:0];
      OP_MULH:   correct_result = hi;
      OP_MULHSU: correct_result = hi + add_a;
      OP_MULHU:  correct_result = hi + add_a + add_b;
      default:   correct_result = hi;
    endcase
  endfunction

  logic              s1_valid_r;
  logic [1:0]        s1_op_r;
  logic [TAG_W-1:0]  s1_rd_r;
  logic [1:0]        op_dec_s;
  logic              s1_advance_s;
  logic              accept_s;
  logic              s2_load_s;
  logic [XLEN-1:0]   corrected_s;

  // Opcode decode. funct3[2] is a don't-care because the decoder only sends
  // multiply ops here.
  always_comb begin
    op_dec_s = OP_MUL;
    casez (funct3)
      3'b?00:  op_dec_s = OP_MUL;
      3'b?01:  op_dec_s = OP_MULH;
      3'b?10:  op_dec_s = OP_MULHSU;
      3'b?11:  op_dec_s = OP_MULHU;
      default: op_dec_s = OP_MUL;
    endcase
  end

  // Handshake logic. A flush blocks the accept, so a request presented in
  // the flush cycle is dropped.
  always_comb begin
    s1_advance_s = s1_valid_r && (!out_valid || out_ready);
    s2_load_s    = s1_advance_s && !flush;
    in_ready     = !flush && (!s1_valid_r || s1_advance_s);
    accept_s     = in_valid && in_ready;
  end

  // Result correction on the current core product.
  always_comb begin
    corrected_s = correct_result(s1_op_r, Product, Multiplier, Multiplicand);
  end

  // Stage 1: operand register. Its data outputs drive the core directly and
  // keep their value after the stage drains.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r   <= 1'b0;
      s1_op_r      <= OP_MUL;
      s1_rd_r      <= {TAG_W{1'b0}};
      Multiplier   <= {XLEN{1'b0}};
      Multiplicand <= {XLEN{1'b0}};
    end else begin
      if (flush) begin
        s1_valid_r <= 1'b0;
      end else if (accept_s) begin
        s1_valid_r <= 1'b1;
      end else if (s1_advance_s) begin
        s1_valid_r <= 1'b0;
      end else begin
        s1_valid_r <= s1_valid_r;
      end
      if (accept_s) begin
        s1_op_r      <= op_dec_s;
        s1_rd_r      <= rd_in;
        Multiplier   <= rs1;
        Multiplicand <= rs2;
      end
    end
  end

  // Stage 2: result register. It holds its data while the consumer stalls.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= {XLEN{1'b0}};
      rd_out    <= {TAG_W{1'b0}};
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (s2_load_s) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
      if (s2_load_s) begin
        result <= corrected_s;
        rd_out <= s1_rd_r;
      end
    end
  end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- Two-stage valid/ready wrapper around the combinational signed 32x32 multiplier core (Multiplier, Multiplicand -> 64-bit signed Product).
- Registers RV32M operands and drives the core.
- Consumes the core's signed Product and applies the unsigned corrections for MULHSU/MULHU.
- Returns the selected 32-bit half with the destination tag to writeback.

Parameters:
- XLEN, 32, operand/result width.
- TAG_W, 5, destination register tag width.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all in-flight ops.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- rs1  input  XLEN  first operand.
- rs2  input  XLEN  second operand.
- rd_in  input  TAG_W  destination tag.
- Multiplier  output  XLEN  to core; registered stage-1 rs1.
- Multiplicand  output  XLEN  to core; registered stage-1 rs2.
- Product  input  2*XLEN  signed product from core, combinational on Multiplier/Multiplicand in the same cycle.
- out_valid  output  1  result valid.
- out_ready  input  1  writeback accepts.
- result  output  XLEN  selected result.
- rd_out  output  TAG_W  tag of result.

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, Multiplier=0, Multiplicand=0, result=0, rd_out=0, out_valid=0. in_ready=1 after reset release.
- Stage 1 (operand register) captures rs1, rs2, funct3[1:0] and rd_in on accept. funct3[2] is ignored; the decoder guarantees it is 0.
- Multiplier/Multiplicand are driven straight from the stage-1 registers and hold their value when the stage empties.
- Stage 2 (result register) captures the corrected result when s1_valid && (!s2_valid || out_ready).
- Correction uses a = stage-1 rs1, b = stage-1 rs2, hi = Product[63:32] mod 2^32:
  - MUL: result = Product[31:0].
  - MULH: result = hi.
  - MULHSU: result = hi + (b[31] ? a : 0).
  - MULHU: result = hi + (a[31] ? b : 0) + (b[31] ? a : 0).
- Handshakes:
  - in_ready = !s1_valid || s1_advance. s1_advance = s1_valid && (!s2_valid || out_ready).
  - The output holds result/rd_out stable while out_valid && !out_ready.
  - Simultaneous output drain, stage advance and new accept all occur in the same cycle.
- Timing: latency is 2 cycles (accept at edge N -> out_valid high after edge N+1), with no bubbles; throughput is 1 op/cycle while out_ready=1.
- Capacity: 2 ops in flight maximum. With out_ready=0, a third op is refused (in_ready=0).
- Ordering: results return in accept order.
- flush=1 at an edge:
  - s1_valid and s2_valid clear; data registers keep their values.
  - A request presented in the same cycle is dropped, and in_ready reads 0 while flush=1.
- Reset mid-operation discards all ops immediately; no stale out_valid after release.

Test Plan:
- MUL rs1=10, rs2=6, out_ready=1 -> result 0x0000003C, out_valid exactly 2 cycles after accept, rd_out matches.
- MULH rs1=0x80000000, rs2=0x80000001 -> Product 0x3FFFFFFF80000000, result 0x3FFFFFFF.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFF. MUL same operands -> 0x00000001.
- Back-to-back 50 random ops, all funct3 codes, out_ready=1 -> one result per cycle, each matching a 64-bit reference model with the correct signedness.
- out_ready=0 with 3 requests -> first two accepted, in_ready low on the third; out_ready=1 -> results in order, third accepted on the drain cycle.
- flush and, separately, rst_n pulse with 2 ops in flight -> out_valid=0 next cycle, no result emitted. The next op after recovery returns correctly.
